// File: rtl/id_stage_pkg.sv
// Shared RV32I decode constants: opcodes, funct fields, ALU op/result encodings
// and immediate extraction helpers used by id_decode and id_stage.
package id_stage_pkg;

  localparam logic [6:0] OpOPI   = 7'b0010011;
  localparam logic [6:0] OpOP    = 7'b0110011;
  localparam logic [6:0] OpLUI   = 7'b0110111;
  localparam logic [6:0] OpAUIPC = 7'b0010111;

  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Sll    = 3'b001;
  localparam logic [2:0] F3Slt    = 3'b010;
  localparam logic [2:0] F3Sltu   = 3'b011;
  localparam logic [2:0] F3Xor    = 3'b100;
  localparam logic [2:0] F3SrlSra = 3'b101;
  localparam logic [2:0] F3Or     = 3'b110;
  localparam logic [2:0] F3And    = 3'b111;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  localparam logic [7:0] EXE_NOP_OP  = 8'h00;
  localparam logic [7:0] EXE_ADD_OP  = 8'h20;
  localparam logic [7:0] EXE_SUB_OP  = 8'h22;
  localparam logic [7:0] EXE_SLT_OP  = 8'h2A;
  localparam logic [7:0] EXE_SLTU_OP = 8'h2B;
  localparam logic [7:0] EXE_AND_OP  = 8'h24;
  localparam logic [7:0] EXE_OR_OP   = 8'h25;
  localparam logic [7:0] EXE_XOR_OP  = 8'h26;
  localparam logic [7:0] EXE_SLL_OP  = 8'h04;
  localparam logic [7:0] EXE_SRL_OP  = 8'h06;
  localparam logic [7:0] EXE_SRA_OP  = 8'h07;

  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_ARITH = 3'b100;

  localparam logic        RstEnable   = 1'b1;
  localparam logic        WriteEnable = 1'b1;
  localparam logic [4:0]  NOPRegAddr  = 5'b00000;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;

  function automatic logic [31:0] imm_i(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:25], inst[11:7]};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] inst);
    return {inst[31:12], 12'h000};
  endfunction

endpackage

// File: rtl/id_decode.sv
// Combinational RV32I decoder for OP-IMM, OP, LUI and AUIPC; anything else is
// flagged illegal with all side effects (reads, write enable, aluop) cleared.
module id_decode
  import id_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 8,
  parameter int ALUSEL_W   = 3
) (
  input  logic [31:0]           inst_i,
  output logic [ALUOP_W-1:0]    aluop_o,
  output logic [ALUSEL_W-1:0]   alusel_o,
  output logic                  read1_o,
  output logic                  read2_o,
  output logic [REG_ADDR_W-1:0] addr1_o,
  output logic [REG_ADDR_W-1:0] addr2_o,
  output logic [XLEN-1:0]       imm_o,
  output logic                  use_pc_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic                  illegal_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];

  always_comb begin
    aluop_o   = ALUOP_W'(EXE_NOP_OP);
    alusel_o  = ALUSEL_W'(EXE_RES_NOP);
    read1_o   = 1'b0;
    read2_o   = 1'b0;
    addr1_o   = REG_ADDR_W'(NOPRegAddr);
    addr2_o   = REG_ADDR_W'(NOPRegAddr);
    imm_o     = XLEN'(ZeroWord);
    use_pc_o  = 1'b0;
    wd_o      = REG_ADDR_W'(NOPRegAddr);
    wreg_o    = 1'b0;
    illegal_o = 1'b0;

    case (opcode)
      OpOPI: begin
        read1_o = 1'b1;
        addr1_o = REG_ADDR_W'(inst_i[19:15]);
        wd_o    = REG_ADDR_W'(inst_i[11:7]);
        wreg_o  = WriteEnable;
        imm_o   = XLEN'($signed(imm_i(inst_i)));
        case (funct3)
          F3AddSub: begin aluop_o = ALUOP_W'(EXE_ADD_OP);  alusel_o = ALUSEL_W'(EXE_RES_ARITH); end
          F3Slt:    begin aluop_o = ALUOP_W'(EXE_SLT_OP);  alusel_o = ALUSEL_W'(EXE_RES_ARITH); end
          F3Sltu:   begin aluop_o = ALUOP_W'(EXE_SLTU_OP); alusel_o = ALUSEL_W'(EXE_RES_ARITH); end
          F3Xor:    begin aluop_o = ALUOP_W'(EXE_XOR_OP);  alusel_o = ALUSEL_W'(EXE_RES_LOGIC); end
          F3Or:     begin aluop_o = ALUOP_W'(EXE_OR_OP);   alusel_o = ALUSEL_W'(EXE_RES_LOGIC); end
          F3And:    begin aluop_o = ALUOP_W'(EXE_AND_OP);  alusel_o = ALUSEL_W'(EXE_RES_LOGIC); end
          F3Sll: begin
            // Shifts carry only the shamt so SRAI's funct7 bit does not leak into the amount.
            imm_o = XLEN'(inst_i[24:20]);
            if (funct7 == F7Base) begin
              aluop_o = ALUOP_W'(EXE_SLL_OP); alusel_o = ALUSEL_W'(EXE_RES_SHIFT);
            end else begin
              illegal_o = 1'b1;
            end
          end
          default: begin
            imm_o = XLEN'(inst_i[24:20]);
            if (funct7 == F7Base) begin
              aluop_o = ALUOP_W'(EXE_SRL_OP); alusel_o = ALUSEL_W'(EXE_RES_SHIFT);
            end else if (funct7 == F7Alt) begin
              aluop_o = ALUOP_W'(EXE_SRA_OP); alusel_o = ALUSEL_W'(EXE_RES_SHIFT);
            end else begin
              illegal_o = 1'b1;
            end
          end
        endcase
      end
      OpOP: begin
        read1_o = 1'b1;
        read2_o = 1'b1;
        addr1_o = REG_ADDR_W'(inst_i[19:15]);
        addr2_o = REG_ADDR_W'(inst_i[24:20]);
        wd_o    = REG_ADDR_W'(inst_i[11:7]);
        wreg_o  = WriteEnable;
        case ({funct7, funct3})
          {F7Base, F3AddSub}: begin aluop_o = ALUOP_W'(EXE_ADD_OP);  alusel_o = ALUSEL_W'(EXE_RES_ARITH); end
          {F7Alt,  F3AddSub}: begin aluop_o = ALUOP_W'(EXE_SUB_OP);  alusel_o = ALUSEL_W'(EXE_RES_ARITH); end
          {F7Base, F3Slt}:    begin aluop_o = ALUOP_W'(EXE_SLT_OP);  alusel_o = ALUSEL_W'(EXE_RES_ARITH); end
          {F7Base, F3Sltu}:   begin aluop_o = ALUOP_W'(EXE_SLTU_OP); alusel_o = ALUSEL_W'(EXE_RES_ARITH); end
          {F7Base, F3Xor}:    begin aluop_o = ALUOP_W'(EXE_XOR_OP);  alusel_o = ALUSEL_W'(EXE_RES_LOGIC); end
          {F7Base, F3Or}:     begin aluop_o = ALUOP_W'(EXE_OR_OP);   alusel_o = ALUSEL_W'(EXE_RES_LOGIC); end
          {F7Base, F3And}:    begin aluop_o = ALUOP_W'(EXE_AND_OP);  alusel_o = ALUSEL_W'(EXE_RES_LOGIC); end
          {F7Base, F3Sll}:    begin aluop_o = ALUOP_W'(EXE_SLL_OP);  alusel_o = ALUSEL_W'(EXE_RES_SHIFT); end
          {F7Base, F3SrlSra}: begin aluop_o = ALUOP_W'(EXE_SRL_OP);  alusel_o = ALUSEL_W'(EXE_RES_SHIFT); end
          {F7Alt,  F3SrlSra}: begin aluop_o = ALUOP_W'(EXE_SRA_OP);  alusel_o = ALUSEL_W'(EXE_RES_SHIFT); end
          default:            illegal_o = 1'b1;
        endcase
      end
      OpLUI, OpAUIPC: begin
        wd_o     = REG_ADDR_W'(inst_i[11:7]);
        wreg_o   = WriteEnable;
        imm_o    = XLEN'($signed(imm_u(inst_i)));
        use_pc_o = (opcode == OpAUIPC);
        aluop_o  = ALUOP_W'(EXE_ADD_OP);
        alusel_o = ALUSEL_W'(EXE_RES_ARITH);
      end
      default: illegal_o = 1'b1;
    endcase

    if (illegal_o) begin
      aluop_o  = ALUOP_W'(EXE_NOP_OP);
      alusel_o = ALUSEL_W'(EXE_RES_NOP);
      read1_o  = 1'b0;
      read2_o  = 1'b0;
      addr1_o  = REG_ADDR_W'(NOPRegAddr);
      addr2_o  = REG_ADDR_W'(NOPRegAddr);
      imm_o    = XLEN'(ZeroWord);
      use_pc_o = 1'b0;
      wd_o     = REG_ADDR_W'(NOPRegAddr);
      wreg_o   = 1'b0;
    end
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: hazard detection, operand selection and the ID/EX register.
// Define ID_FORWARD_EN for EX/MEM forwarding; otherwise any RAW stalls instead.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 8,
  parameter int ALUSEL_W   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid_i,
  output logic                  if_ready_o,
  input  logic [XLEN-1:0]       pc_i,
  input  logic [31:0]           inst_i,
  output logic                  reg1_read_o,
  output logic                  reg2_read_o,
  output logic [REG_ADDR_W-1:0] reg1_addr_o,
  output logic [REG_ADDR_W-1:0] reg2_addr_o,
  input  logic [XLEN-1:0]       reg1_data_i,
  input  logic [XLEN-1:0]       reg2_data_i,
  input  logic                  ex_wreg_i,
  input  logic [REG_ADDR_W-1:0] ex_wd_i,
  input  logic [XLEN-1:0]       ex_wdata_i,
  input  logic                  ex_is_load_i,
  input  logic                  mem_wreg_i,
  input  logic [REG_ADDR_W-1:0] mem_wd_i,
  input  logic [XLEN-1:0]       mem_wdata_i,
  input  logic                  flush_i,
  output logic                  ex_valid_o,
  input  logic                  ex_ready_i,
  output logic [ALUOP_W-1:0]    aluop_o,
  output logic [ALUSEL_W-1:0]   alusel_o,
  output logic [XLEN-1:0]       reg1_o,
  output logic [XLEN-1:0]       reg2_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [XLEN-1:0]       pc_o,
  output logic                  illegal_o
);

  logic [ALUOP_W-1:0]    dec_aluop;
  logic [ALUSEL_W-1:0]   dec_alusel;
  logic                  dec_read1, dec_read2, dec_use_pc, dec_wreg, dec_illegal;
  logic [REG_ADDR_W-1:0] dec_addr1, dec_addr2, dec_wd;
  logic [XLEN-1:0]       dec_imm;

  id_decode #(
    .XLEN      (XLEN),
    .REG_ADDR_W(REG_ADDR_W),
    .ALUOP_W   (ALUOP_W),
    .ALUSEL_W  (ALUSEL_W)
  ) u_decode (
    .inst_i   (inst_i),
    .aluop_o  (dec_aluop),
    .alusel_o (dec_alusel),
    .read1_o  (dec_read1),
    .read2_o  (dec_read2),
    .addr1_o  (dec_addr1),
    .addr2_o  (dec_addr2),
    .imm_o    (dec_imm),
    .use_pc_o (dec_use_pc),
    .wd_o     (dec_wd),
    .wreg_o   (dec_wreg),
    .illegal_o(dec_illegal)
  );

  logic            ex_raw1, ex_raw2, load_use, stall, accept;
  logic [XLEN-1:0] src1, src2, op1_val, op2_val;

  assign ex_raw1  = dec_read1 && ex_wreg_i && (ex_wd_i != '0) && (dec_addr1 == ex_wd_i);
  assign ex_raw2  = dec_read2 && ex_wreg_i && (ex_wd_i != '0) && (dec_addr2 == ex_wd_i);
  assign load_use = if_valid_i && ex_is_load_i && (ex_raw1 || ex_raw2);

`ifdef ID_FORWARD_EN
  assign stall = load_use;

  always_comb begin
    src1 = reg1_data_i;
    if (dec_addr1 == '0)                          src1 = '0;
    else if (ex_wreg_i && ex_wd_i == dec_addr1)   src1 = ex_wdata_i;
    else if (mem_wreg_i && mem_wd_i == dec_addr1) src1 = mem_wdata_i;
    src2 = reg2_data_i;
    if (dec_addr2 == '0)                          src2 = '0;
    else if (ex_wreg_i && ex_wd_i == dec_addr2)   src2 = ex_wdata_i;
    else if (mem_wreg_i && mem_wd_i == dec_addr2) src2 = mem_wdata_i;
  end
`else
  logic mem_raw1, mem_raw2;
  logic unused_fwd_data;

  assign mem_raw1 = dec_read1 && mem_wreg_i && (mem_wd_i != '0) && (dec_addr1 == mem_wd_i);
  assign mem_raw2 = dec_read2 && mem_wreg_i && (mem_wd_i != '0) && (dec_addr2 == mem_wd_i);
  // Without forwarding the stage waits until the writer has retired past MEM.
  assign stall    = load_use || (if_valid_i && (ex_raw1 || ex_raw2 || mem_raw1 || mem_raw2));
  assign src1     = (dec_addr1 == '0) ? '0 : reg1_data_i;
  assign src2     = (dec_addr2 == '0) ? '0 : reg2_data_i;
  assign unused_fwd_data = ^{ex_wdata_i, mem_wdata_i};
`endif

  assign op1_val = dec_read1 ? src1 : (dec_use_pc ? pc_i : '0);
  assign op2_val = dec_read2 ? src2 : dec_imm;

  logic                  valid_q, valid_d;
  logic [ALUOP_W-1:0]    aluop_q, aluop_d;
  logic [ALUSEL_W-1:0]   alusel_q, alusel_d;
  logic [XLEN-1:0]       reg1_q, reg1_d, reg2_q, reg2_d, pc_q, pc_d;
  logic [REG_ADDR_W-1:0] wd_q, wd_d;
  logic                  wreg_q, wreg_d, illegal_q, illegal_d;

  assign if_ready_o  = !rst && !stall && (!valid_q || ex_ready_i);
  assign accept      = if_valid_i && if_ready_o;
  assign reg1_read_o = !rst && dec_read1;
  assign reg2_read_o = !rst && dec_read2;
  assign reg1_addr_o = rst ? '0 : dec_addr1;
  assign reg2_addr_o = rst ? '0 : dec_addr2;

  always_comb begin
    valid_d   = valid_q;
    aluop_d   = aluop_q;
    alusel_d  = alusel_q;
    reg1_d    = reg1_q;
    reg2_d    = reg2_q;
    wd_d      = wd_q;
    wreg_d    = wreg_q;
    pc_d      = pc_q;
    illegal_d = illegal_q;
    if (flush_i) begin
      valid_d = 1'b0;
      wreg_d  = 1'b0;
    end else if (accept) begin
      valid_d   = 1'b1;
      aluop_d   = dec_aluop;
      alusel_d  = dec_alusel;
      reg1_d    = op1_val;
      reg2_d    = op2_val;
      wd_d      = dec_wd;
      wreg_d    = dec_wreg;
      pc_d      = pc_i;
      illegal_d = dec_illegal;
    end else if (ex_ready_i) begin
      valid_d = 1'b0;
      wreg_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      valid_q   <= 1'b0;
      aluop_q   <= ALUOP_W'(EXE_NOP_OP);
      alusel_q  <= ALUSEL_W'(EXE_RES_NOP);
      reg1_q    <= '0;
      reg2_q    <= '0;
      wd_q      <= '0;
      wreg_q    <= 1'b0;
      pc_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      aluop_q   <= aluop_d;
      alusel_q  <= alusel_d;
      reg1_q    <= reg1_d;
      reg2_q    <= reg2_d;
      wd_q      <= wd_d;
      wreg_q    <= wreg_d;
      pc_q      <= pc_d;
      illegal_q <= illegal_d;
    end
  end

  assign ex_valid_o = valid_q;
  assign aluop_o    = aluop_q;
  assign alusel_o   = alusel_q;
  assign reg1_o     = reg1_q;
  assign reg2_o     = reg2_q;
  assign wd_o       = wd_q;
  assign wreg_o     = wreg_q;
  assign pc_o       = pc_q;
  assign illegal_o  = illegal_q;

endmodule
